// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg
// Shared definitions for the Sobel convolution blocks: frame-scheduler state
// encoding, bank-index width and default engine timeout.
// Revision: 1.0
// ============================================================================
package conv_pkg;

  // Scheduler state encoding (3-bit, stable values shared with later blocks)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_START   = ST_START,
    S_RUN     = ST_RUN,
    S_RELEASE = ST_RELEASE,
    S_DRAIN   = ST_DRAIN,
    S_ERR     = ST_ERR
  } sched_state_t;

  // Two ping-pong input banks -> one index bit
  localparam int BANK_W = 1;

  // Default hung-engine limit in RUN cycles
  localparam int TIMEOUT_CYCLES_DEF = 1048576;

  // Default frame-counter width
  localparam int CNT_W_DEF = 16;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
// conv_sched
// Frame scheduler for the Sobel engine: ping-pong input bank tracking,
// level-held start/done handshake, result back-pressure, frame counting,
// completion interrupt and hung-engine watchdog.
// Revision: 1.0
// ============================================================================
module conv_sched
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             abort,
  output logic             load_ready,
  output logic             load_bank,
  input  logic             load_done,
  output logic             conv_start,
  output logic             conv_bank,
  input  logic             conv_done,
  output logic             out_full,
  input  logic             out_ack,
  output logic             irq,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_load,
  output logic             err_timeout,
  output logic             busy
);

  // Watchdog counter is one bit wider than needed so TIMEOUT_CYCLES-1 always fits
  localparam int              TC_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

  sched_state_t    state;
  logic [1:0]      full;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [TC_W-1:0] tcnt;
  logic            seen_done;

  logic            load_fire;
  logic            release_fire;
  logic            start_ok;

  // Loader view is a pure decode of registered bank state
  assign load_bank  = wr_ptr;
  assign load_ready = ~full[wr_ptr];

  // A load is accepted only when the target bank is empty and no flush is in progress
  assign load_fire    = load_done & load_ready & ~abort;
  // Frame retires on the cycle the engine drops done while in RELEASE
  assign release_fire = (state == S_RELEASE) & ~conv_done & ~abort;
  // Start a frame only when a bank is full, the result slot is free and the engine is idle
  assign start_ok     = enable & full[rd_ptr] & ~out_full & ~conv_done;

  // Bank tracker: load and retire always hit different banks, so both may update together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      err_load <= 1'b0;
    end else if (abort) begin
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (load_done && !load_ready) begin
        err_load <= 1'b1;
      end
      if (load_fire) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (release_fire) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  // Scheduler FSM with registered handshake, status and counter outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      conv_start  <= 1'b0;
      conv_bank   <= 1'b0;
      out_full    <= 1'b0;
      frames_done <= '0;
      irq         <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      tcnt        <= '0;
      seen_done   <= 1'b0;
    end else begin
      irq <= 1'b0;
      // Consumer ack; a same-cycle retire below overrides it
      if (out_ack) begin
        out_full <= 1'b0;
      end
      if (abort) begin
        out_full   <= 1'b0;
        tcnt       <= '0;
        conv_start <= 1'b0;
        unique case (state)
          // Engine may still be busy: wait for its done cycle before idling
          S_START, S_RUN: begin
            state     <= S_DRAIN;
            busy      <= 1'b1;
            seen_done <= conv_done;
          end
          S_DRAIN: begin
            state     <= S_DRAIN;
            busy      <= 1'b1;
            seen_done <= seen_done | conv_done;
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            seen_done <= 1'b0;
          end
        endcase
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_ok) begin
              state <= S_START;
              busy  <= 1'b1;
            end
          end
          S_START: begin
            conv_bank  <= rd_ptr;
            conv_start <= 1'b1;
            tcnt       <= '0;
            state      <= S_RUN;
          end
          S_RUN: begin
            if (conv_done) begin
              conv_start <= 1'b0;
              state      <= S_RELEASE;
            end else if (tcnt == TC_LAST) begin
              conv_start  <= 1'b0;
              err_timeout <= 1'b1;
              state       <= S_ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (!conv_done) begin
              out_full    <= 1'b1;
              frames_done <= frames_done + 1'b1;
              irq         <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (conv_done) begin
              seen_done <= 1'b1;
            end else if (seen_done) begin
              seen_done <= 1'b0;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end
          end
          S_ERR: begin
            state <= S_ERR;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : conv_sched
`default_nettype wire

// File: tb/tb_conv_sched.sv
`default_nettype none
// ============================================================================
// tb_conv_sched
// Directed bench for conv_sched with a bank-queue reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
// Revision: 1.0
// ============================================================================
module tb_conv_sched;

  localparam int TO  = 64;
  localparam int LAT = 20;

  // Reference-model job phases
  localparam int J_NONE   = 0;
  localparam int J_ARMED  = 1;
  localparam int J_RUN    = 2;
  localparam int J_FINISH = 3;
  localparam int J_DRAIN  = 4;
  localparam int J_HUNG   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        load_done = 1'b0;
  logic        out_ack = 1'b0;
  logic        load_ready, load_bank, conv_start, conv_bank, out_full;
  logic        irq, err_load, err_timeout, busy;
  logic [15:0] frames_done;
  logic        conv_done;
  logic        eng_done = 1'b0;
  logic        man_done = 1'b0;
  bit          eng_hang = 1'b0;
  int          eng_cnt = 0;

  int npass = 0;
  int ntot  = 0;
  int irq_cnt = 0;

  assign conv_done = eng_done | man_done;

  conv_sched #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .load_ready(load_ready), .load_bank(load_bank), .load_done(load_done),
    .conv_start(conv_start), .conv_bank(conv_bank), .conv_done(conv_done),
    .out_full(out_full), .out_ack(out_ack), .irq(irq),
    .frames_done(frames_done), .err_load(err_load),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Engine stand-in: done rises LAT cycles after start, falls once start drops
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_done = 1'b0;
      eng_cnt  = 0;
    end else if (eng_done) begin
      if (!conv_start) eng_done = 1'b0;
    end else if (conv_start && !eng_hang) begin
      eng_cnt++;
      if (eng_cnt >= LAT) begin
        eng_done = 1'b1;
        eng_cnt  = 0;
      end
    end else begin
      eng_cnt = 0;
    end
  end

  always @(negedge clk) if (irq) irq_cnt++;

  // Reference model: filled banks held as a FIFO of bank indices
  bit          m_q[$];
  bit          m_wr, m_outfull, m_errload, m_errto, m_irq, m_start, m_bank, m_seen;
  logic [15:0] m_frames;
  int          ph, m_runs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wr = 0; m_outfull = 0; m_errload = 0; m_errto = 0; m_irq = 0;
      m_start = 0; m_bank = 0; m_seen = 0; m_frames = '0; ph = J_NONE; m_runs = 0;
    end else begin
      automatic bit room      = (m_q.size() < 2);
      automatic bit can_start = enable && (m_q.size() > 0) && !m_outfull && !conv_done;
      m_irq = 0;
      if (abort) begin
        m_q.delete();
        m_wr = 0; m_outfull = 0; m_start = 0;
        if (ph == J_ARMED || ph == J_RUN) begin ph = J_DRAIN; m_seen = conv_done; end
        else if (ph == J_DRAIN) m_seen = m_seen | conv_done;
        else begin ph = J_NONE; m_seen = 0; end
      end else begin
        if (load_done) begin
          if (room) begin m_q.push_back(m_wr); m_wr = !m_wr; end
          else m_errload = 1;
        end
        if (out_ack) m_outfull = 0;
        case (ph)
          J_NONE:   if (can_start) ph = J_ARMED;
          J_ARMED:  begin m_start = 1; m_bank = m_q[0]; m_runs = 0; ph = J_RUN; end
          J_RUN: begin
            if (conv_done) begin m_start = 0; ph = J_FINISH; end
            else begin
              m_runs++;
              if (m_runs == TO) begin m_start = 0; m_errto = 1; ph = J_HUNG; end
            end
          end
          J_FINISH: if (!conv_done) begin
            void'(m_q.pop_front());
            m_outfull = 1; m_frames = m_frames + 16'd1; m_irq = 1; ph = J_NONE;
          end
          J_DRAIN: begin
            if (conv_done) m_seen = 1;
            else if (m_seen) begin ph = J_NONE; m_seen = 0; end
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("load_ready",  load_ready,  (m_q.size() < 2));
    chk("load_bank",   load_bank,   m_wr);
    chk("conv_start",  conv_start,  m_start);
    chk("conv_bank",   conv_bank,   m_bank);
    chk("out_full",    out_full,    m_outfull);
    chk("irq",         irq,         m_irq);
    chk("frames_done", frames_done, m_frames);
    chk("err_load",    err_load,    m_errload);
    chk("err_timeout", err_timeout, m_errto);
    chk("busy",        busy,        (ph != J_NONE));
  end

  task automatic wait_until(input int which, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk); #1; n++;
      if ((which == 0 && conv_start) || (which == 1 && irq)) return;
    end
    n = maxc + 1;
  endtask

  task automatic do_load();
    @(negedge clk) load_done = 1'b1;
    @(negedge clk) load_done = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk) out_ack = 1'b1;
    @(negedge clk) out_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, hi, irq_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_conv_start", conv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_load_bank", load_bank, 0);
    @(negedge clk) rst_n = 1'b1;
    enable = 1'b1;

    // Single frame
    @(negedge clk) load_done = 1'b1;
    @(posedge clk); #1;
    chk("load_bank_toggle", load_bank, 1);
    @(negedge clk) load_done = 1'b0;
    wait_until(0, 10, n);
    chk("start_latency", n + 1, 3);
    chk("f1_conv_bank", conv_bank, 0);
    wait_until(1, 200, n);
    chk("f1_irq", irq, 1);
    chk("f1_frames", frames_done, 1);
    chk("f1_out_full", out_full, 1);
    chk("f1_start_low", conv_start, 0);

    // Ping-pong with back-pressure, plus overrun
    do_load();
    do_load();
    repeat (10) @(negedge clk);
    chk("bp_no_start", conv_start, 0);
    chk("bp_not_ready", load_ready, 0);
    do_load();
    chk("ovr_err_load", err_load, 1);
    chk("ovr_not_ready", load_ready, 0);
    chk("ovr_load_bank", load_bank, 1);
    do_ack();
    wait_until(0, 20, n);
    chk("f2_start", conv_start, 1);
    chk("f2_conv_bank", conv_bank, 1);
    wait_until(1, 200, n);
    chk("f2_frames", frames_done, 2);
    do_ack();
    wait_until(0, 20, n);
    chk("f3_conv_bank", conv_bank, 0);
    wait_until(1, 200, n);
    chk("f3_frames", frames_done, 3);
    do_ack();

    // Engine timeout
    eng_hang = 1'b1;
    do_load();
    wait_until(0, 20, n);
    chk("to_start", conv_start, 1);
    hi = 1;
    while (hi < 200) begin
      @(posedge clk); #1;
      if (!conv_start) break;
      hi++;
    end
    chk("to_run_cycles", hi, 64);
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 1);
    do_abort();
    eng_hang = 1'b0;
    chk("to_abort_idle", busy, 0);
    chk("to_err_sticky", err_timeout, 1);
    chk("to_load_bank", load_bank, 0);

    // Abort mid-run, then drain on a manual done pulse
    do_load();
    wait_until(0, 20, n);
    repeat (5) @(negedge clk);
    irq_before = irq_cnt;
    do_abort();
    chk("ab_drain_busy", busy, 1);
    chk("ab_start_low", conv_start, 0);
    chk("ab_load_bank", load_bank, 0);
    chk("ab_load_ready", load_ready, 1);
    @(negedge clk) man_done = 1'b1;
    repeat (2) @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_idle", busy, 0);
    chk("ab_frames", frames_done, 3);
    chk("ab_no_irq", irq_cnt, irq_before);

    // Enable gates starts
    enable = 1'b0;
    do_load();
    repeat (8) @(negedge clk);
    chk("en_low_no_start", conv_start, 0);
    enable = 1'b1;
    wait_until(0, 10, n);
    chk("en_high_start", conv_start, 1);

    // Reset mid-frame
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_conv_start", conv_start, 0);
    chk("mr_busy", busy, 0);
    chk("mr_frames", frames_done, 0);
    chk("mr_err_load", err_load, 0);
    chk("mr_err_timeout", err_timeout, 0);
    chk("mr_load_bank", load_bank, 0);
    @(negedge clk) rst_n = 1'b1;
    do_load();
    wait_until(1, 200, n);
    chk("mr_resume_irq", irq, 1);
    chk("mr_resume_frames", frames_done, 1);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule : tb_conv_sched
`default_nettype wire
